// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key schedule: one shared round-expansion unit computes one
// round key per cycle into an 11-entry store that has a registered read port.

module key_expand_round (
    input  logic [3:0]   rc,
    input  logic [127:0] key,
    output logic [127:0] keyout
);
    // Byte x of the S-box is at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[(11'd2047 - {x, 3'b000}) -: 8];
    endfunction

    logic [7:0]  w_rcon;
    logic [31:0] w_w0;
    logic [31:0] w_w1;
    logic [31:0] w_w2;
    logic [31:0] w_w3;
    logic [31:0] w_temp;
    logic [31:0] w_n0;
    logic [31:0] w_n1;
    logic [31:0] w_n2;
    logic [31:0] w_n3;

    always_comb begin
        case (rc)
            4'h1:    w_rcon = 8'h01;
            4'h2:    w_rcon = 8'h02;
            4'h3:    w_rcon = 8'h04;
            4'h4:    w_rcon = 8'h08;
            4'h5:    w_rcon = 8'h10;
            4'h6:    w_rcon = 8'h20;
            4'h7:    w_rcon = 8'h40;
            4'h8:    w_rcon = 8'h80;
            4'h9:    w_rcon = 8'h1b;
            4'hA:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign {w_w0, w_w1, w_w2, w_w3} = key;

    // SubWord(RotWord(w3)) xor Rcon
    assign w_temp = {sbox(w_w3[23:16]) ^ w_rcon, sbox(w_w3[15:8]),
                     sbox(w_w3[7:0]), sbox(w_w3[31:24])};

    assign w_n0   = w_w0 ^ w_temp;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign keyout = {w_n0, w_n1, w_n2, w_n3};
endmodule

module key_schedule_ctrl #(
    parameter int unsigned CLR_ON_START = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         rd_valid,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;

    logic [1:0]   r_state;
    logic [3:0]   r_round;
    logic [127:0] r_key;
    logic [127:0] r_rk [0:10];
    logic         r_keys_valid;
    logic         r_rd_valid;
    logic [127:0] r_rd_data;

    logic         w_accept;
    logic         w_last;
    logic [3:0]   w_prev_idx;
    logic [127:0] w_prev;
    logic [127:0] w_next;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last     = (r_state == S_EXPAND) && (r_round == 4'd10);
    assign w_prev_idx = (r_round == 4'd0) ? 4'd0 : r_round - 4'd1;
    assign w_prev     = r_rk[w_prev_idx];

    key_expand_round u_round (
        .rc     (r_round),
        .key    (w_prev),
        .keyout (w_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_round      <= '0;
            r_key        <= '0;
            r_keys_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_LOAD;
                        r_key        <= key_in;
                        r_keys_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_state <= S_EXPAND;
                    r_round <= 4'd1;
                end
                S_EXPAND: begin
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        r_round      <= '0;
                        r_keys_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Clearing at the accept edge makes rk[1..10] read as zero during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            if (w_accept && (CLR_ON_START != 0)) begin
                for (int unsigned i = 0; i < 11; i++) r_rk[i] <= '0;
            end
            if (r_state == S_LOAD) r_rk[0] <= r_key;
            if (r_state == S_EXPAND) r_rk[r_round] <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= (rd_idx <= 4'd10) ? r_rk[rd_idx] : '0;
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign busy       = (r_state != S_IDLE);
    assign done       = w_last;
    assign keys_valid = r_keys_valid;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: read expectations go through a scoreboard queue
// drained by a monitor; status outputs are checked cycle by cycle.

module tb_key_schedule_ctrl;
    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A_RK9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
    } rd_exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         busy;
    logic         done;
    logic         keys_valid;

    int      checks;
    int      errors;
    rd_exp_t exp_q[$];

    key_schedule_ctrl #(.CLR_ON_START(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
        rd_exp_t e;
        rd_en  = 1'b1;
        rd_idx = idx;
        e.idx  = idx;
        e.data = exp;
        exp_q.push_back(e);
    endtask

    // Start from an IDLE cycle N, then check status through cycle N+12.
    task automatic expand_and_check(input logic [127:0] key, input string tag);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = '1;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("%s_busy_c%0d", tag, c), busy, (c <= 11));
            chk($sformatf("%s_done_c%0d", tag, c), done, (c == 11));
            chk($sformatf("%s_kv_c%0d", tag, c), keys_valid, (c == 12));
            if (c < 12) tick();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%h expected=no read pending", rd_data);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd_idx%0d", e.idx), rd_data, e.data);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rd_en  = 1'b0;
        rd_idx = '0;

        // Reset state
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_keys_valid", keys_valid, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        rst = 1'b0;
        tick();
        rd(4'd1, '0);
        tick();
        rd_en = 1'b0;
        tick();

        // FIPS-197 key; key_in is scrambled after the start to test capture
        expand_and_check(KEY_A, "fips");
        rd(4'd15, '0);      tick();
        rd(4'd0, KEY_A);    tick();
        rd(4'd1, A_RK1);    tick();
        rd(4'd2, A_RK2);    tick();
        rd(4'd9, A_RK9);    tick();
        rd(4'd10, A_RK10);  tick();
        rd_en  = 1'b0;
        rd_idx = 4'd3;
        tick();
        chk("hold_rd_valid", rd_valid, 1'b0);
        chk("hold_rd_data", rd_data, A_RK10);

        // start held high: second expansion accepted at N+12, zero key
        key_in = '0;
        start  = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 16) start = 1'b0;
            chk($sformatf("b2b_busy_c%0d", c), busy, ((c <= 11) || (c >= 13 && c <= 23)));
            chk($sformatf("b2b_done_c%0d", c), done, ((c == 11) || (c == 23)));
            chk($sformatf("b2b_kv_c%0d", c), keys_valid, ((c == 12) || (c == 24)));
            rd_en = 1'b0;
            case (c)
                1:  rd(4'd1, '0);
                11: rd(4'd10, '0);
                12: rd(4'd10, Z_RK10);
                13: rd(4'd10, '0);
                24: rd(4'd1, Z_RK1);
                default: ;
            endcase
        end
        tick(); rd(4'd2, Z_RK2);
        tick(); rd(4'd10, Z_RK10);
        tick(); rd(4'd0, '0);
        tick(); rd_en = 1'b0;
        tick();

        // Reset at N+5 abandons the expansion
        key_in = KEY_A;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_kv", keys_valid, 1'b0);
        chk("midrst_rd_valid", rd_valid, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("postrst_done_c%0d", c), done, 1'b0);
            chk($sformatf("postrst_busy_c%0d", c), busy, 1'b0);
            chk($sformatf("postrst_kv_c%0d", c), keys_valid, 1'b0);
            tick();
        end
        rd(4'd1, '0); tick();
        rd(4'd0, '0); tick();
        rd_en = 1'b0;
        tick();

        // First start after reset proceeds normally
        expand_and_check(KEY_A, "again");
        rd(4'd10, A_RK10); tick();
        rd(4'd1, A_RK1);   tick();
        rd_en = 1'b0;
        tick(); tick();

        chk("rd_queue_drained", 128'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL have parameter CLR_ON_START, default 1: when 1, all stored round keys are cleared to zero on an accepted start.
REQ-002 The block SHALL have a single clock and an asynchronous, active-high reset, with ports as follows.
REQ-003 clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 start, input, 1 bit: request expansion of key_in; sampled only in IDLE.
REQ-006 key_in, input, 128 bits: AES-128 cipher key; bit 127 is byte 0 MSB; sampled on an accepted start.
REQ-007 rd_en, input, 1 bit: round-key read request.
REQ-008 rd_idx, input, 4 bits: round-key index, 0..10.
REQ-009 rd_data, output, 128 bits: registered round-key read data.
REQ-010 rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-011 busy, output, 1 bit: expansion in progress.
REQ-012 done, output, 1 bit: one-cycle pulse when round key 10 is written.
REQ-013 keys_valid, output, 1 bit: all 11 round keys hold the result of the last accepted start.

Function
REQ-014 The block SHALL instantiate one one-round key-expansion unit (rc, key[127:0] -> keyout[127:0]) and reuse it once per round; it SHALL contain no other S-box logic.
REQ-015 The block SHALL store 11 x 128-bit round keys, rk[0..10].
REQ-016 The FSM SHALL have states IDLE, LOAD and EXPAND; reset state IDLE.
REQ-017 IDLE SHALL transition to LOAD on start=1 (the accepted start, cycle N); start in any other state SHALL be ignored.
REQ-018 LOAD (cycle N+1) SHALL write rk[0]=key_in as captured at N, set round counter=1, assert busy, clear keys_valid, and go to EXPAND.
REQ-019 EXPAND SHALL present rc=round and key=rk[round-1] to the expansion unit, write rk[round]=keyout each cycle, and increment round.
REQ-020 rc SHALL run 4'h1..4'hA; round 10 SHALL use Rcon 0x36 and round 9 SHALL use Rcon 0x1B, with outputs matching FIPS-197.
REQ-021 rk[10] SHALL be written at cycle N+11; in the same cycle done=1 and the FSM SHALL return to IDLE.
REQ-022 busy SHALL be 1 in cycles N+1..N+11 inclusive and 0 otherwise.
REQ-023 keys_valid SHALL be 1 from cycle N+12 until the next accepted start or reset.
REQ-024 Back-to-back: start=1 at N+11 SHALL be ignored; start=1 at N+12 SHALL be accepted.
REQ-025 Reads SHALL have 1-cycle latency: rd_en=1 at cycle M gives rd_data=rk[rd_idx] and rd_valid=1 at M+1.
REQ-026 When rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its previous value.
REQ-027 rd_idx>10 SHALL return rd_data=0 with rd_valid=1.
REQ-028 Reads SHALL be allowed in every state.
REQ-029 A read of rk[i] in the same cycle that rk[i] is written SHALL return the old value.
REQ-030 If CLR_ON_START=1, rk[1..10] SHALL be zero in cycle N+1.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, round=0, busy=0, done=0, keys_valid=0, rd_valid=0, rd_data=0 and all rk[]=0.
REQ-032 Reset mid-expansion SHALL abandon the expansion with no done pulse.
REQ-033 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-034 Key 2b7e151628aed2a6abf7158809cf4f3c, start at N -> done at N+11; rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 Key all-zero -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-036 start held high through N+15 -> exactly one expansion from N and a second start accepted at N+12; busy=0 only at N+12.
REQ-037 rst pulsed at N+5 -> busy=0, keys_valid=0, no done pulse; rd_idx=1 read returns 0.
REQ-038 Reads after completion: rd_idx=0 returns key_in, rd_idx=15 returns 0 with rd_valid=1, and rd_en=0 gives rd_valid=0 with data held.
REQ-039 Second key started at N+12 -> keys_valid=0 during busy; new rk10 readable once keys_valid=1.
